// File: rtl/neuron_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module  : neuron_mult_pipe
// Brief   : Two-stage per-lane fixed-point multiplier with scaling shift,
//           saturation, sticky per-lane saturation flags and valid/ready
//           backpressure. Define MULT_ROUND_EN for round-half-up scaling.
// Revision: 1.0 - initial release
// ============================================================================
module neuron_mult_pipe #(
  parameter int NEURONS = 4,
  parameter int WIDTH   = 8,
  parameter int FRAC    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       signed_mode,
  input  logic [NEURONS*WIDTH-1:0]   a,
  input  logic [NEURONS*WIDTH-1:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEURONS*WIDTH-1:0]   res,
  output logic [NEURONS-1:0]         sat_flag,
  input  logic                       sat_clr
);

  localparam int c_pw  = 2 * WIDTH;
  // Two guard bits keep the rounded unsigned maximum positive in a signed view
  localparam int c_ew  = 2 * WIDTH + 2;
  localparam int c_rsh = (FRAC > 0) ? FRAC - 1 : 0;
`ifdef MULT_ROUND_EN
  localparam logic [c_ew-1:0] c_round = (FRAC > 0) ? (c_ew'(1) << c_rsh) : '0;
`else
  localparam logic [c_ew-1:0] c_round = '0;
`endif

  logic                     w_adv;
  logic                     r_s1_valid;
  logic                     r_s1_signed;
  logic [c_pw-1:0]          r_prod [NEURONS];
  logic [c_pw-1:0]          w_prod [NEURONS];
  logic [NEURONS*WIDTH-1:0] w_res_nxt;
  logic [NEURONS*WIDTH-1:0] r_res;
  logic [NEURONS-1:0]       w_clamp;
  logic [NEURONS-1:0]       r_sat;
  logic                     r_out_valid;

  assign w_adv     = !r_out_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign sat_flag  = r_sat;

  for (genvar i = 0; i < NEURONS; i++) begin : g_lane
    logic [WIDTH-1:0]        w_a;
    logic [WIDTH-1:0]        w_b;
    logic [c_pw-1:0]         w_ax;
    logic [c_pw-1:0]         w_bx;
    logic signed [c_ew-1:0]  w_ext;
    logic signed [c_ew-1:0]  w_sum;
    logic signed [c_ew-1:0]  w_shift;
    logic                    w_neg;
    logic [WIDTH-1:0]        w_lane;
    logic                    w_lane_clamp;

    assign w_a = a[i*WIDTH +: WIDTH];
    assign w_b = b[i*WIDTH +: WIDTH];
    // Extending operands by mode lets one 2W-bit multiplier serve both modes
    assign w_ax = {{WIDTH{signed_mode & w_a[WIDTH-1]}}, w_a};
    assign w_bx = {{WIDTH{signed_mode & w_b[WIDTH-1]}}, w_b};
    assign w_prod[i] = w_ax * w_bx;

    assign w_ext   = {{2{r_s1_signed & r_prod[i][c_pw-1]}}, r_prod[i]};
    assign w_sum   = w_ext + $signed(c_round);
    assign w_shift = w_sum >>> FRAC;
    assign w_neg   = w_shift[c_ew-1];

    always_comb begin
      w_lane       = w_shift[WIDTH-1:0];
      w_lane_clamp = 1'b0;
      if (r_s1_signed) begin
        if (!w_neg && (|w_shift[c_ew-1:WIDTH-1])) begin
          w_lane       = {1'b0, {(WIDTH-1){1'b1}}};
          w_lane_clamp = 1'b1;
        end else if (w_neg && !(&w_shift[c_ew-1:WIDTH-1])) begin
          w_lane       = {1'b1, {(WIDTH-1){1'b0}}};
          w_lane_clamp = 1'b1;
        end
      end else if (|w_shift[c_ew-1:WIDTH]) begin
        w_lane       = '1;
        w_lane_clamp = 1'b1;
      end
    end

    assign w_res_nxt[i*WIDTH +: WIDTH] = w_lane;
    assign w_clamp[i]                  = w_lane_clamp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_signed <= 1'b0;
      r_prod      <= '{default: '0};
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_sat       <= '0;
    end else begin
      if (w_adv) begin
        r_s1_valid  <= in_valid;
        r_s1_signed <= signed_mode;
        r_prod      <= w_prod;
        r_out_valid <= r_s1_valid;
        r_res       <= w_res_nxt;
      end
      // Set term is OR-ed last so a same-cycle clamp beats sat_clr
      r_sat <= (r_sat & ~{NEURONS{sat_clr}})
             | (w_clamp & {NEURONS{w_adv & r_s1_valid}});
    end
  end

endmodule
`default_nettype wire
